// File: rtl/apb_manager_if.sv
// Command/response streams plus the APB requester-side pins of one apb_manager.
interface apb_manager_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 cmdValid;
  logic                 cmdReady;
  logic [AddrWidth-1:0] cmdAddr;
  logic                 cmdWrite;
  logic [DataWidth-1:0] cmdWData;

  logic                 rspValid;
  logic                 rspReady;
  logic [DataWidth-1:0] rspRData;
  logic                 rspErr;
  logic                 rspTimeout;

  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wData;
  logic                 write;
  logic                 sel;
  logic                 enable;
  logic [DataWidth-1:0] rData;
  logic                 subErr;
  logic                 readyOut;

  modport master (
    input  cmdValid, cmdAddr, cmdWrite, cmdWData, rspReady, rData, subErr, readyOut,
    output cmdReady, rspValid, rspRData, rspErr, rspTimeout, addr, wData, write, sel, enable
  );

  modport slave (
    output cmdValid, cmdAddr, cmdWrite, cmdWData, rspReady, rData, subErr, readyOut,
    input  cmdReady, rspValid, rspRData, rspErr, rspTimeout, addr, wData, write, sel, enable
  );
endinterface

// File: rtl/apb_manager.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer and one response.
// Latency: response valid 3 cycles after accept plus one cycle per readyOut-low ACCESS cycle.
// Backpressure: held response stalls cmdReady; a command can be taken on the response handshake.
module apb_manager #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16,
  parameter int CntWidth      = 8
) (
  input  logic          clk,
  input  logic          nReset,
  apb_manager_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int TimeoutLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  state_t              state;
  state_t              state_nxt;
  logic [CntWidth-1:0] wait_cnt;
  logic                accept;
  logic                done;
  logic                timeout;

  assign accept  = bus.cmdValid && bus.cmdReady;
  assign done    = (state == ACCESS) && bus.readyOut;
  // readyOut on the expiry edge takes priority, so timeout is qualified by !readyOut
  assign timeout = (TimeoutCycles > 0) && (state == ACCESS) && !bus.readyOut &&
                   (wait_cnt == CntWidth'(TimeoutLast));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmdValid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || timeout) state_nxt = RESP;
      RESP:    if (bus.rspReady) state_nxt = bus.cmdValid ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // APB strobes decode straight from the state register, so reset drops them asynchronously
  always_comb begin
    bus.cmdReady = (state == IDLE) || ((state == RESP) && bus.rspReady);
    bus.sel      = (state == SETUP) || (state == ACCESS);
    bus.enable   = (state == ACCESS);
    bus.rspValid = (state == RESP);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      bus.addr       <= {AddrWidth{1'b0}};
      bus.wData      <= {DataWidth{1'b0}};
      bus.write      <= 1'b0;
      bus.rspRData   <= {DataWidth{1'b0}};
      bus.rspErr     <= 1'b0;
      bus.rspTimeout <= 1'b0;
    end else begin
      if (accept) begin
        bus.addr  <= bus.cmdAddr;
        bus.write <= bus.cmdWrite;
        bus.wData <= bus.cmdWData;
      end
      if (done) begin
        bus.rspRData   <= bus.write ? {DataWidth{1'b0}} : bus.rData;
        bus.rspErr     <= bus.subErr;
        bus.rspTimeout <= 1'b0;
      end else if (timeout) begin
        bus.rspRData   <= {DataWidth{1'b0}};
        bus.rspErr     <= 1'b1;
        bus.rspTimeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)                                         wait_cnt <= '0;
    else if ((state == ACCESS) && !bus.readyOut && !timeout) wait_cnt <= wait_cnt + 1'b1;
    else                                                 wait_cnt <= '0;
  end

endmodule

// File: tb/tb_apb_manager.sv
// Directed plus randomized bench for apb_manager against a transfer-level reference model.
module tb_apb_manager;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] cur_addr, cur_wdata;
  logic        cur_write;
  logic [31:0] exp_rdata;
  logic        exp_err, exp_to;

  apb_manager_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  apb_manager #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO), .CntWidth(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a transfer sees (waits) low-ready ACCESS cycles then one ready cycle,
  // unless the watchdog ends it after TO low cycles.
  task automatic model(input logic wr, input int waits, input logic [31:0] rd, input logic err,
                       output int cycles);
    logic timed;
    timed     = (TO > 0) && (waits >= TO);
    cycles    = timed ? TO : waits + 1;
    exp_to    = timed;
    exp_err   = timed ? 1'b1 : err;
    exp_rdata = (timed || wr) ? 32'h0 : rd;
  endtask

  task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    bus.cmdAddr  = a;
    bus.cmdWrite = wr;
    bus.cmdWData = wd;
    bus.cmdValid = 1'b1;
    #1 check("cmd_ready_idle", {31'b0, bus.cmdReady}, 32'd1);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    bus.cmdAddr  = $urandom;
    bus.cmdWData = $urandom;
    bus.readyOut = 1'($urandom_range(0, 1));
    cur_addr = a; cur_write = wr; cur_wdata = wd;
    check("setup_sel", {31'b0, bus.sel}, 32'd1);
    check("setup_enable", {31'b0, bus.enable}, 32'd0);
    check("setup_addr", bus.addr, a);
    check("setup_write", {31'b0, bus.write}, {31'b0, wr});
    check("setup_wdata", bus.wData, wd);
  endtask

  task automatic complete(input int waits, input logic [31:0] rd, input logic err);
    int  n;
    int  cycles;
    bit  fin;
    n = 0;
    fin = 0;
    model(cur_write, waits, rd, err, cycles);
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (bus.enable) begin
        n++;
        check("access_addr", bus.addr, cur_addr);
        check("access_sel", {31'b0, bus.sel}, 32'd1);
        if (n > waits) begin
          bus.readyOut = 1'b1; bus.rData = rd; bus.subErr = err;
        end else begin
          bus.readyOut = 1'b0; bus.rData = $urandom; bus.subErr = 1'($urandom_range(0, 1));
        end
      end else begin
        fin = 1;
      end
    end
    bus.readyOut = 1'b0;
    check("access_ended", {31'b0, fin}, 32'd1);
    check("enable_cycles", n, cycles);
    check("resp_sel", {31'b0, bus.sel}, 32'd0);
    check("rsp_valid", {31'b0, bus.rspValid}, 32'd1);
    check("rsp_rdata", bus.rspRData, exp_rdata);
    check("rsp_err", {31'b0, bus.rspErr}, {31'b0, exp_err});
    check("rsp_timeout", {31'b0, bus.rspTimeout}, {31'b0, exp_to});
  endtask

  task automatic hold_rsp(input int hold);
    bus.rspReady = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      #1 check("held_valid", {31'b0, bus.rspValid}, 32'd1);
      check("held_rdata", bus.rspRData, exp_rdata);
      check("held_err", {31'b0, bus.rspErr}, {31'b0, exp_err});
      check("held_cmd_ready", {31'b0, bus.cmdReady}, 32'd0);
    end
  endtask

  task automatic release_rsp(input int hold);
    hold_rsp(hold);
    bus.rspReady = 1'b1;
    #1 check("rsp_cmd_ready", {31'b0, bus.cmdReady}, 32'd1);
    @(negedge clk);
    bus.rspReady = 1'b0;
    check("idle_valid", {31'b0, bus.rspValid}, 32'd0);
    check("idle_sel", {31'b0, bus.sel}, 32'd0);
    check("idle_addr_hold", bus.addr, cur_addr);
  endtask

  initial begin
    logic [31:0] a, wd, rd;
    logic        wr, er;
    int          w;

    bus.cmdValid = 1'b0; bus.cmdAddr = '0; bus.cmdWrite = 1'b0; bus.cmdWData = '0;
    bus.rspReady = 1'b0; bus.rData = '0; bus.subErr = 1'b0; bus.readyOut = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_sel", {31'b0, bus.sel}, 32'd0);
    check("rst_enable", {31'b0, bus.enable}, 32'd0);
    check("rst_write", {31'b0, bus.write}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rspValid}, 32'd0);
    check("rst_rsp_err", {31'b0, bus.rspErr}, 32'd0);
    check("rst_rsp_timeout", {31'b0, bus.rspTimeout}, 32'd0);
    check("rst_addr", bus.addr, 32'd0);
    check("rst_wdata", bus.wData, 32'd0);
    check("rst_rsp_rdata", bus.rspRData, 32'd0);
    nReset = 1'b1;
    @(negedge clk);

    // zero-wait write
    issue(32'h4, 1'b1, 32'h0000_A5A5);
    complete(0, 32'hDEAD_BEEF, 1'b0);
    release_rsp(0);

    // read with three wait states
    issue(32'h0, 1'b0, 32'h0);
    complete(3, 32'h0000_1234, 1'b0);
    release_rsp(1);

    // subordinate error
    issue(32'h8, 1'b0, 32'h0);
    complete(0, 32'h0000_5555, 1'b1);
    release_rsp(0);
    check("err_idle_cmd_ready", {31'b0, bus.cmdReady}, 32'd1);

    // watchdog: readyOut never comes
    issue(32'hC, 1'b0, 32'h0);
    complete(100, 32'h1111_2222, 1'b0);
    release_rsp(0);

    // response backpressure, then back-to-back accept on the handshake
    issue(32'h10, 1'b1, 32'h0BAD_F00D);
    complete(1, 32'h0, 1'b0);
    bus.cmdValid = 1'b1; bus.cmdAddr = 32'h20; bus.cmdWrite = 1'b0; bus.cmdWData = 32'h77;
    hold_rsp(5);
    bus.rspReady = 1'b1;
    #1 check("b2b_cmd_ready", {31'b0, bus.cmdReady}, 32'd1);
    @(negedge clk);
    bus.rspReady = 1'b0; bus.cmdValid = 1'b0;
    cur_addr = 32'h20; cur_write = 1'b0;
    check("b2b_setup_sel", {31'b0, bus.sel}, 32'd1);
    check("b2b_setup_enable", {31'b0, bus.enable}, 32'd0);
    check("b2b_rsp_valid", {31'b0, bus.rspValid}, 32'd0);
    check("b2b_addr", bus.addr, 32'h20);
    complete(0, 32'hCAFE_0001, 1'b0);
    release_rsp(0);

    // reset during ACCESS
    issue(32'h30, 1'b1, 32'h1234_5678);
    bus.readyOut = 1'b0;
    @(negedge clk);
    check("pre_rst_enable", {31'b0, bus.enable}, 32'd1);
    #2 nReset = 1'b0;
    #1 check("rst_async_sel", {31'b0, bus.sel}, 32'd0);
    check("rst_async_enable", {31'b0, bus.enable}, 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'b0, bus.rspValid}, 32'd0);
    end
    issue(32'h34, 1'b0, 32'h0);
    complete(2, 32'h0F0F_0F0F, 1'b0);
    release_rsp(0);

    // randomized transfers against the model
    for (int i = 0; i < 20; i++) begin
      a  = $urandom & 32'hFFFF_FFFC;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      rd = $urandom;
      er = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 6);
      issue(a, wr, wd);
      complete(w, rd, er);
      release_rsp($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
